dac_spi_tx: RTL and testbench

Downstream consumer of the sine generator. It takes signed 16-bit samples qualified by a one-cycle strobe and converts each to offset binary. Each sample is then shifted out as one SPI frame to an external 16-bit DAC: 8-bit command byte followed by 16-bit code, SPI mode 0, MSB first. It holds one pending sample, keeps only the latest, and flags overruns.

---
 rtl/dac_spi_pkg.sv | 29 ++
 rtl/spi_sclk_tick.sv | 37 +++
 rtl/dac_spi_tx.sv | 204 ++++++++++++++++++++
 tb/tb_dac_spi_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// ============================================================================
// Module : dac_spi_pkg
// Brief  : Shared FSM encoding, DAC frame constants and offset-binary helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int         DATA_W_DEF  = 16;
  localparam int         CMD_W_DEF   = 8;
  localparam logic [7:0] DAC_CMD_DEF = 8'h30;   // write-and-update channel A
  localparam int         FRAME_W     = CMD_W_DEF + DATA_W_DEF;

  // Two's complement to offset binary is a flip of the sign bit.
  function automatic logic [15:0] to_offset_bin(input logic signed [15:0] s);
    return {~s[15], s[14:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_tick.sv
// ============================================================================
// Module : spi_sclk_tick
// Brief  : Half-period divider; o_tick marks the last clk of each SCLK phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sclk_tick #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] c_last = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module : dac_spi_tx
// Brief  : Sample-to-SPI DAC transmitter (cmd byte + 16-bit offset-binary code,
//          mode 0, MSB first) with a single latest-wins hold register.
//          Optional macro DAC_LDAC_EN adds an LDAC strobe after each frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int               DATA_W    = DATA_W_DEF,
  parameter int               CMD_W     = CMD_W_DEF,
  parameter logic [CMD_W-1:0] DAC_CMD   = DAC_CMD_DEF,
  parameter int               SCLK_HALF = 2,
  parameter int               CS_GAP    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_sample_valid,
  input  logic                     i_clear_overrun,
  output logic                     o_spi_sclk,
  output logic                     o_spi_mosi,
  output logic                     o_spi_cs_n,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_overrun
`ifdef DAC_LDAC_EN
  ,
  output logic                     o_ldac_n
`endif
);

  localparam int FRAME_LEN = CMD_W + DATA_W;
  localparam int BW        = $clog2(FRAME_LEN + 1);
`ifdef DAC_LDAC_EN
  localparam int GAP_LEN   = (CS_GAP > SCLK_HALF + 1) ? CS_GAP : SCLK_HALF + 1;
`else
  localparam int GAP_LEN   = CS_GAP;
`endif
  localparam int GW        = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [BW-1:0] c_bits     = BW'(FRAME_LEN);
  localparam logic [GW-1:0] c_gap_last = GW'(GAP_LEN - 1);

  state_t                 r_state, w_state_nxt;
  logic [DATA_W-1:0]      r_hold;
  logic                   r_hold_full;
  logic                   r_overrun;
  logic [FRAME_LEN-1:0]   r_shreg, w_shreg_nxt;
  logic [BW-1:0]          r_bit_cnt, w_bit_nxt;
  logic [GW-1:0]          r_gap_cnt, w_gap_nxt;
  logic                   r_sclk, w_sclk_nxt;
  logic                   r_mosi, w_mosi_nxt;
  logic                   r_cs_n, w_cs_n_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_drain;
  logic                   w_ovr_set;
  logic                   w_tick;

  // The IDLE cycle that launches a frame is the only time the hold register drains.
  assign w_drain   = (r_state == ST_IDLE) && r_hold_full;
  assign w_ovr_set = i_sample_valid && r_hold_full && !w_drain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_sample_valid) begin
        r_hold      <= to_offset_bin(i_sample);
        r_hold_full <= 1'b1;
      end else if (w_drain) begin
        r_hold_full <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  spi_sclk_tick #(
    .HALF (SCLK_HALF)
  ) u_tick (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_en      (r_state != ST_IDLE),
    .i_restart (w_drain),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_cs_n_nxt  = r_cs_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = ST_SETUP;
          w_shreg_nxt = {DAC_CMD, r_hold};
          w_mosi_nxt  = DAC_CMD[CMD_W-1];
          w_bit_nxt   = '0;
          w_cs_n_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_bit_nxt   = BW'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            w_sclk_nxt  = 1'b0;
            w_mosi_nxt  = r_shreg[FRAME_LEN-2];
            w_shreg_nxt = r_shreg << 1;
          end else if (r_bit_cnt == c_bits) begin
            // Final low phase elapsed: close the frame.
            w_cs_n_nxt  = 1'b1;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_sclk_nxt = 1'b1;
            w_bit_nxt  = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_gap_last) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

`ifdef DAC_LDAC_EN
  logic r_ldac_n;

  // Low for SCLK_HALF cycles beginning one cycle after cs_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ldac_n <= 1'b1;
    end else begin
      r_ldac_n <= !((r_state == ST_GAP) && (int'(r_gap_cnt) < SCLK_HALF));
    end
  end

  assign o_ldac_n = r_ldac_n;
`endif

  assign o_spi_sclk   = r_sclk;
  assign o_spi_mosi   = r_mosi;
  assign o_spi_cs_n   = r_cs_n;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;
  assign o_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// Module : tb_dac_spi_tx
// Brief  : Self-checking bench for dac_spi_tx: cycle-level timing model plus
//          directed frame/latency/overrun/reset checks (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dac_spi_tx;

  localparam int H         = 2;
  localparam int G         = 2;
  localparam int NB        = 24;
  localparam int FRAME_CYC = H * (1 + 2 * NB);
  localparam int BUSY_CYC  = FRAME_CYC + G;

  logic               clk     = 1'b0;
  logic               reset_n = 1'b1;
  logic signed [15:0] sample  = '0;
  logic               valid   = 1'b0;
  logic               clr     = 1'b0;
  logic               sclk, mosi, cs_n, busy, fd, ovr;

  int n_checks = 0;
  int n_pass   = 0;

  dac_spi_tx dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_sample        (sample),
    .i_sample_valid  (valid),
    .i_clear_overrun (clr),
    .o_spi_sclk      (sclk),
    .o_spi_mosi      (mosi),
    .o_spi_cs_n      (cs_n),
    .o_busy          (busy),
    .o_frame_done    (fd),
    .o_overrun       (ovr)
  );

  always #50 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- transaction-level timing model ----------------
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [23:0] m_word = '0;
  bit          m_hold_full = 1'b0;
  logic [15:0] m_hold = '0;
  bit          m_ovr = 1'b0;
  bit          m_idle, m_drain, m_set;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active    = 1'b0;
      m_hold_full = 1'b0;
      m_ovr       = 1'b0;
    end else begin
      m_idle  = !m_active || (cyc - m_start >= BUSY_CYC);
      m_drain = m_idle && m_hold_full;
      if (m_drain) begin
        m_word   = {8'h30, m_hold};
        m_start  = cyc + 1;
        m_active = 1'b1;
      end
      m_set = valid && m_hold_full && !m_drain;
      if (valid) begin
        m_hold      = sample ^ 16'h8000;
        m_hold_full = 1'b1;
      end else if (m_drain) begin
        m_hold_full = 1'b0;
      end
      if (m_set) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
    cyc++;
  end

  // ---------------- per-cycle compare and frame monitor ----------------
  logic [23:0] obs_word[$];
  int          obs_rise[$];
  int          obs_low[$];
  int          obs_gap[$];
  logic [23:0] cap = '0;
  int          rises = 0, low = 0, high_cnt = 999, cur_gap = 0, k = 0, idx = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  logic        e_sclk, e_mosi;
  bit          ov_seen = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      rises     = 0;
      low       = 0;
      cap       = '0;
      high_cnt  = 999;
    end else begin
      k      = m_active ? (cyc - m_start) : (1 << 20);
      idx    = k / (2 * H);
      e_sclk = (k >= H) && (k < 2 * H * NB) && (((k - H) / H) % 2 == 0);
      e_mosi = (idx < NB) ? m_word[NB-1-idx] : 1'b0;
      chk1($sformatf("cs_n@%0d", cyc), cs_n, !(k < FRAME_CYC));
      chk1($sformatf("sclk@%0d", cyc), sclk, e_sclk);
      chk1($sformatf("mosi@%0d", cyc), mosi, e_mosi);
      chk1($sformatf("busy@%0d", cyc), busy, k < BUSY_CYC);
      chk1($sformatf("frame_done@%0d", cyc), fd, k == FRAME_CYC);
      chk1($sformatf("overrun@%0d", cyc), ovr, m_ovr);
      if (ovr) ov_seen = 1'b1;
      if (!cs_n) begin
        if (prev_cs) begin
          cur_gap = high_cnt;
          rises   = 0;
          low     = 0;
          cap     = '0;
        end
        low++;
        if (sclk && !prev_sclk) begin
          cap = {cap[22:0], mosi};
          rises++;
        end
      end else begin
        if (!prev_cs) begin
          obs_word.push_back(cap);
          obs_rise.push_back(rises);
          obs_low.push_back(low);
          obs_gap.push_back(cur_gap);
          high_cnt = 0;
        end
        high_cnt++;
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [15:0] s);
    sample = s;
    valid  = 1'b1;
    idle(1);
    valid  = 1'b0;
  endtask

  task automatic clear_obs();
    obs_word.delete();
    obs_rise.delete();
    obs_low.delete();
    obs_gap.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (obs_word.size() < n && i < budget) begin
      idle(1);
      i++;
    end
    chk1($sformatf("frame_wait_%0d", n), obs_word.size() >= n, 1'b1);
  endtask

  logic [23:0] exp_q[$];
  logic [15:0] s_tmp;
  int          wi;

  initial begin
    #10 reset_n = 1'b0;
    idle(4);
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_sclk", sclk, 1'b0);
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_frame_done", fd, 1'b0);
    chk1("rst_overrun", ovr, 1'b0);
    reset_n = 1'b1;
    idle(3);

    // Zero sample: latency t+2, 24 rises, 98 low cycles.
    clear_obs();
    pulse(16'h0000);
    chk1("lat_t1_cs_n", cs_n, 1'b1);
    idle(1);
    chk1("lat_t2_cs_n", cs_n, 1'b0);
    chk1("lat_t2_busy", busy, 1'b1);
    wait_frames(1, 400);
    if (obs_word.size() >= 1) begin
      chkv("zero_word", 32'(obs_word[0]), 32'h0030_8000);
      chkv("zero_rises", obs_rise[0], 32'd24);
      chkv("zero_cs_low", obs_low[0], 32'd98);
    end
    idle(5);

    clear_obs();
    pulse(16'sd32000);
    wait_frames(1, 400);
    if (obs_word.size() >= 1) chkv("pos32000_word", 32'(obs_word[0]), 32'h0030_FD00);
    idle(5);

    clear_obs();
    pulse(-16'sd32000);
    wait_frames(1, 400);
    if (obs_word.size() >= 1) chkv("neg32000_word", 32'(obs_word[0]), 32'h0030_0300);
    idle(5);

    // Back-to-back overwrite: 2 is replaced by 3 while frame 1 is in flight.
    clear_obs();
    pulse(16'h0001);
    idle(9);
    pulse(16'h0002);
    idle(9);
    pulse(16'h0003);
    wait_frames(2, 600);
    if (obs_word.size() >= 2) begin
      chkv("b2b_word0", 32'(obs_word[0]), 32'h0030_8001);
      chkv("b2b_word1", 32'(obs_word[1]), 32'h0030_8003);
    end
    idle(10);
    chkv("b2b_frame_count", obs_word.size(), 32'd2);
    chk1("b2b_overrun_set", ovr, 1'b1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk1("b2b_overrun_cleared", ovr, 1'b0);
    idle(5);

    // Second valid on the load cycle: no overrun, gap = CS_GAP plus the IDLE cycle.
    clear_obs();
    pulse(16'h1234);
    pulse(16'hF00D);
    wait_frames(2, 600);
    if (obs_word.size() >= 2) begin
      chkv("sim_word0", 32'(obs_word[0]), 32'h0030_9234);
      chkv("sim_word1", 32'(obs_word[1]), 32'h0030_700D);
      chkv("sim_cs_gap", obs_gap[1], 32'(G + 1));
    end
    chk1("sim_overrun", ovr, 1'b0);
    idle(5);

    // Reset at bit 10 aborts the frame; nothing follows after release.
    clear_obs();
    pulse(16'h5555);
    wi = 0;
    while (!(rises == 10 && !cs_n) && wi < 400) begin
      idle(1);
      wi++;
    end
    chk1("rst_mid_reached_bit10", wi < 400, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("rst_mid_cs_n", cs_n, 1'b1);
    chk1("rst_mid_sclk", sclk, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    idle(3);
    reset_n = 1'b1;
    idle(300);
    chkv("rst_mid_no_frame", obs_word.size(), 32'd0);
    chk1("rst_mid_idle_cs_n", cs_n, 1'b1);

    // Upstream rate: one sample every 156 cycles.
    clear_obs();
    exp_q.delete();
    ov_seen = 1'b0;
    for (int i = 0; i < 128; i++) begin
      s_tmp = 16'(i * 509 - 32000);
      exp_q.push_back({8'h30, s_tmp ^ 16'h8000});
      pulse(s_tmp);
      idle(155);
    end
    wait_frames(128, 400);
    chkv("stream_frame_count", obs_word.size(), 32'd128);
    for (int i = 0; i < 128; i++) begin
      if (i < obs_word.size()) chkv($sformatf("stream_word%0d", i), 32'(obs_word[i]), 32'(exp_q[i]));
    end
    chk1("stream_overrun_never", ov_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
